booth_csa_accumulator: RTL

//  Sequential radix-4 Booth multiply-accumulate front end. Accepts signed operand pairs, compresses one

---
 rtl/booth_csa_accumulator.sv | 129 ++++++++++++
 1 files changed

// File: rtl/booth_csa_accumulator.sv
// rtl/booth_csa_accumulator.sv - sequential radix-4 Booth multiply-accumulate with carry-save accumulator
// One Booth partial product is compressed per cycle into a sum/carry pair; no carry-propagate adder here.
module booth_csa_accumulator #(
    parameter int DATA_BITS = 16,
    parameter int ACC_BITS  = 40
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATA_BITS-1:0] in_a_i,
    input  logic [DATA_BITS-1:0] in_b_i,
    input  logic                 in_clr_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ACC_BITS-1:0]  sum_vec_o,
    output logic [ACC_BITS-1:0]  carry_vec_o
);

    localparam int STEPS = DATA_BITS / 2;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int NW    = DATA_BITS + 2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e              state_q, state_d;
    logic [ACC_BITS-1:0] sum_q, sum_d;
    logic [ACC_BITS-1:0] carry_q, carry_d;
    logic [ACC_BITS-1:0] pa_q, pa_d, na_q, na_d, p2a_q, p2a_d, n2a_q, n2a_d;
    logic [DATA_BITS:0]  b_q, b_d;
    logic [SW-1:0]       step_q, step_d;

    // Multiples are formed at DATA_BITS+2 width, where +/-2A of any operand still fits, then sign-extended.
    logic [NW-1:0]       a_ext, a_neg, a_dbl, a_dbl_neg;
    logic [ACC_BITS-1:0] pp_sel, pp, maj;

    assign a_ext     = {{2{in_a_i[DATA_BITS-1]}}, in_a_i};
    assign a_neg     = -a_ext;
    assign a_dbl     = a_ext << 1;
    assign a_dbl_neg = -a_dbl;

    always_comb begin
        pp_sel = '0;
        case (b_q[2:0])
            3'b001, 3'b010: pp_sel = pa_q;
            3'b011:         pp_sel = p2a_q;
            3'b100:         pp_sel = n2a_q;
            3'b101, 3'b110: pp_sel = na_q;
            default:        pp_sel = '0;
        endcase
    end

    assign pp  = pp_sel << {step_q, 1'b0};
    assign maj = (sum_q & carry_q) | (sum_q & pp) | (carry_q & pp);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        pa_d    = pa_q;
        na_d    = na_q;
        p2a_d   = p2a_q;
        n2a_d   = n2a_q;
        b_d     = b_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    pa_d    = {{(ACC_BITS-NW){a_ext[NW-1]}}, a_ext};
                    na_d    = {{(ACC_BITS-NW){a_neg[NW-1]}}, a_neg};
                    p2a_d   = {{(ACC_BITS-NW){a_dbl[NW-1]}}, a_dbl};
                    n2a_d   = {{(ACC_BITS-NW){a_dbl_neg[NW-1]}}, a_dbl_neg};
                    b_d     = {in_b_i, 1'b0};
                    step_d  = '0;
                    state_d = BUSY;
                    if (in_clr_i) begin
                        sum_d   = '0;
                        carry_d = '0;
                    end
                end
            end
            BUSY: begin
                sum_d   = sum_q ^ carry_q ^ pp;
                carry_d = {maj[ACC_BITS-2:0], 1'b0};
                b_d     = b_q >> 2;
                step_d  = step_q + SW'(1);
                if (step_q == SW'(STEPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sum_q   <= '0;
            carry_q <= '0;
            pa_q    <= '0;
            na_q    <= '0;
            p2a_q   <= '0;
            n2a_q   <= '0;
            b_q     <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            pa_q    <= pa_d;
            na_q    <= na_d;
            p2a_q   <= p2a_d;
            n2a_q   <= n2a_d;
            b_q     <= b_d;
            step_q  <= step_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign sum_vec_o   = sum_q;
    assign carry_vec_o = carry_q;

endmodule
